// File: rtl/ahb_apb_pkg.sv
// Shared AHB2APB bridge definitions: AHB transfer/response encodings, slave-interface
// FSM state type and the default peripheral address map.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    StOkay,
    StErr1,
    StErr2
  } slv_state_e;

  localparam logic [31:0] DEF_SLV_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV_SPAN = 32'h0400_0000;

endpackage

// File: rtl/ahb_slave_interface_if.sv
// AHB-side bus bundle of the bridge front end: master-driven address/data/control,
// APB-controller read data/ready, and the pipelined/decoded outputs of the slave interface.
interface ahb_slave_interface_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 3
);
  logic              hwrite;
  logic              hready_in;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready_ctl;

  logic               valid;
  logic [ADDR_W-1:0]  haddr1;
  logic [ADDR_W-1:0]  haddr2;
  logic [DATA_W-1:0]  hwdata1;
  logic [DATA_W-1:0]  hwdata2;
  logic               hwrite_reg;
  logic               hwrite_reg1;
  logic [NUM_SLV-1:0] temp_selx;
  logic [1:0]         hresp;
  logic               hr_readyout;
  logic [DATA_W-1:0]  hrdata;

  modport master (
    output hwrite, hready_in, htrans, haddr, hwdata, prdata, pready_ctl,
    input  valid, haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1,
    input  temp_selx, hresp, hr_readyout, hrdata
  );

  modport slave (
    input  hwrite, hready_in, htrans, haddr, hwdata, prdata, pready_ctl,
    output valid, haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1,
    output temp_selx, hresp, hr_readyout, hrdata
  );

endinterface

// File: rtl/ahb_addr_decoder.sv
// Combinational peripheral decode: in_map range check and one-hot select, bounds
// evaluated one bit wider than the address so the top of the map cannot wrap.
module ahb_addr_decoder #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       NUM_SLV  = 3,
  parameter logic [ADDR_W-1:0] SLV_BASE = ahb_apb_pkg::DEF_SLV_BASE,
  parameter logic [ADDR_W-1:0] SLV_SPAN = ahb_apb_pkg::DEF_SLV_SPAN
) (
  input  logic [ADDR_W-1:0]  i_haddr,
  output logic               o_in_map,
  output logic [NUM_SLV-1:0] o_selx
);

  localparam logic [ADDR_W:0] BaseExt = {1'b0, SLV_BASE};
  localparam logic [ADDR_W:0] SpanExt = {1'b0, SLV_SPAN};
  localparam logic [ADDR_W:0] MapHi   = BaseExt + (ADDR_W+1)'(NUM_SLV) * SpanExt;

  logic [ADDR_W:0] w_addr_ext;
  assign w_addr_ext = {1'b0, i_haddr};

  assign o_in_map = (w_addr_ext >= BaseExt) && (w_addr_ext < MapHi);

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_win
    localparam logic [ADDR_W:0] WinLo = BaseExt + (ADDR_W+1)'(k) * SpanExt;
    localparam logic [ADDR_W:0] WinHi = WinLo + SpanExt;
    assign o_selx[k] = (w_addr_ext >= WinLo) && (w_addr_ext < WinHi);
  end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the AHB2APB bridge: two-deep address/data pipeline, transfer
// qualification and peripheral select. Define AHB_SLV_ERROR_RESP_EN for the ERROR response FSM.
module ahb_slave_interface
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NUM_SLV  = 3,
  parameter logic [ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [ADDR_W-1:0] SLV_SPAN = DEF_SLV_SPAN
) (
  input logic            hclk,
  input logic            hreset,
  ahb_slave_interface_if.slave bus
);

  logic               w_in_map;
  logic [NUM_SLV-1:0] w_selx;
  logic               w_live;

  ahb_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SLV_BASE(SLV_BASE),
    .SLV_SPAN(SLV_SPAN)
  ) u_addr_decoder (
    .i_haddr (bus.haddr),
    .o_in_map(w_in_map),
    .o_selx  (w_selx)
  );

  logic [ADDR_W-1:0] r_haddr1, r_haddr2;
  logic [DATA_W-1:0] r_hwdata1, r_hwdata2;
  logic              r_hwrite1, r_hwrite2;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_haddr1  <= '0;
      r_haddr2  <= '0;
      r_hwdata1 <= '0;
      r_hwdata2 <= '0;
      r_hwrite1 <= 1'b0;
      r_hwrite2 <= 1'b0;
    end else if (bus.hready_in) begin
      r_haddr1  <= bus.haddr;
      r_haddr2  <= r_haddr1;
      r_hwdata1 <= bus.hwdata;
      r_hwdata2 <= r_hwdata1;
      r_hwrite1 <= bus.hwrite;
      r_hwrite2 <= r_hwrite1;
    end
  end

  assign bus.haddr1      = r_haddr1;
  assign bus.haddr2      = r_haddr2;
  assign bus.hwdata1     = r_hwdata1;
  assign bus.hwdata2     = r_hwdata2;
  assign bus.hwrite_reg  = r_hwrite1;
  assign bus.hwrite_reg1 = r_hwrite2;
  assign bus.temp_selx   = w_selx;
  assign bus.hrdata      = bus.prdata;

  assign w_live = bus.hready_in & bus.htrans[1];

`ifdef AHB_SLV_ERROR_RESP_EN
  slv_state_e r_state;
  logic [1:0] r_hresp;
  logic       r_err_ready;

  // Two-cycle ERROR: first cycle stalls the master, second completes it.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= StOkay;
      r_hresp     <= HRESP_OKAY;
      r_err_ready <= 1'b0;
    end else begin
      unique case (r_state)
        StOkay: begin
          if (w_live && !w_in_map) begin
            r_state     <= StErr1;
            r_hresp     <= HRESP_ERROR;
            r_err_ready <= 1'b0;
          end
        end
        StErr1: begin
          r_state     <= StErr2;
          r_err_ready <= 1'b1;
        end
        StErr2: begin
          r_state     <= StOkay;
          r_hresp     <= HRESP_OKAY;
          r_err_ready <= 1'b0;
        end
        default: begin
          r_state     <= StOkay;
          r_hresp     <= HRESP_OKAY;
          r_err_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid       = w_live & w_in_map & (r_state == StOkay);
  assign bus.hresp       = r_hresp;
  assign bus.hr_readyout = (r_state == StOkay) ? bus.pready_ctl : r_err_ready;
`else
  assign bus.valid       = w_live & w_in_map;
  assign bus.hresp       = HRESP_OKAY;
  assign bus.hr_readyout = bus.pready_ctl;
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Scoreboard bench for ahb_slave_interface: each driven cycle pushes the spec-derived
// expectation, which is popped and compared mid-cycle against the DUT outputs.
module tb_ahb_slave_interface;
  import ahb_apb_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0400_0000;

  logic clk = 1'b0;
  logic hreset;
  always #5 clk = ~clk;

  ahb_slave_interface_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bus ();

  ahb_slave_interface #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NUM_SLV (3),
    .SLV_BASE(BASE),
    .SLV_SPAN(SPAN)
  ) u_dut (
    .hclk  (clk),
    .hreset(hreset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  selx;
    logic [31:0] a1, a2, d1, d2;
    logic        w1, w2;
    logic [1:0]  resp;
    logic        rdy;
    logic [31:0] rdata;
  } exp_t;

  exp_t q_exp[$];
  int n_total = 0;
  int n_bad = 0;

  // Reference state: pipeline stages and error state (0=OKAY,1=ERR1,2=ERR2).
  logic [31:0] m_a1 = '0, m_a2 = '0, m_d1 = '0, m_d2 = '0;
  logic        m_w1 = 1'b0, m_w2 = 1'b0;
  int          m_st = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] a, output logic in_map,
                                     output logic [2:0] sel);
    longint unsigned la;
    la = longint'(a);
    in_map = (la >= longint'(BASE)) && (la < longint'(BASE) + 3 * longint'(SPAN));
    sel = in_map ? (3'b001 << ((la - longint'(BASE)) / longint'(SPAN))) : 3'b000;
  endfunction

  task automatic cyc(input logic rst, input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic [31:0] wd, input logic rdy,
                     input logic [31:0] pd, input logic prdy);
    exp_t e;
    logic in_map;
    logic [2:0] sel;
    hreset = rst;
    bus.htrans = tr;
    bus.haddr = a;
    bus.hwrite = w;
    bus.hwdata = wd;
    bus.hready_in = rdy;
    bus.prdata = pd;
    bus.pready_ctl = prdy;
    ref_decode(a, in_map, sel);
    e.valid = rdy & tr[1] & in_map & (m_st == 0);
    e.selx  = sel;
    e.a1 = m_a1; e.a2 = m_a2; e.d1 = m_d1; e.d2 = m_d2; e.w1 = m_w1; e.w2 = m_w2;
    e.resp  = (m_st == 0) ? HRESP_OKAY : HRESP_ERROR;
    e.rdy   = (m_st == 0) ? prdy : (m_st == 2);
    e.rdata = pd;
    q_exp.push_back(e);

    @(negedge clk);
    e = q_exp.pop_front();
    check("valid", 32'(bus.valid), 32'(e.valid));
    check("temp_selx", 32'(bus.temp_selx), 32'(e.selx));
    check("haddr1", bus.haddr1, e.a1);
    check("haddr2", bus.haddr2, e.a2);
    check("hwdata1", bus.hwdata1, e.d1);
    check("hwdata2", bus.hwdata2, e.d2);
    check("hwrite_reg", 32'(bus.hwrite_reg), 32'(e.w1));
    check("hwrite_reg1", 32'(bus.hwrite_reg1), 32'(e.w2));
    check("hresp", 32'(bus.hresp), 32'(e.resp));
    check("hr_readyout", 32'(bus.hr_readyout), 32'(e.rdy));
    check("hrdata", bus.hrdata, e.rdata);

    @(posedge clk);
    if (rst) begin
      m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w1 = 1'b0; m_w2 = 1'b0; m_st = 0;
    end else begin
      if (rdy) begin
        m_a2 = m_a1; m_a1 = a;
        m_d2 = m_d1; m_d1 = wd;
        m_w2 = m_w1; m_w1 = w;
      end
`ifdef AHB_SLV_ERROR_RESP_EN
      case (m_st)
        0: if (rdy && tr[1] && !in_map) m_st = 1;
        1: m_st = 2;
        default: m_st = 0;
      endcase
`endif
    end
    #1;
  endtask

  // Shorthand for an ordinary cycle with ready high and no reset.
  task automatic go(input logic [1:0] tr, input logic [31:0] a, input logic w,
                    input logic [31:0] wd);
    cyc(1'b0, tr, a, w, wd, 1'b1, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] addr_pool [8];
    hreset = 1'b1;
    bus.htrans = HTRANS_IDLE; bus.haddr = '0; bus.hwrite = 1'b0; bus.hwdata = '0;
    bus.hready_in = 1'b1; bus.prdata = '0; bus.pready_ctl = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state, with pready_ctl low to see hr_readyout follow it.
    cyc(1'b1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

    // Single write, data one cycle after address.
    go(HTRANS_NONSEQ, 32'h8000_0000, 1'b1, 32'h0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h24);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

    // Single read, hrdata passthrough.
    cyc(1'b0, HTRANS_NONSEQ, 32'h8400_0010, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cyc(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // INCR4 write to peripheral 2, then IDLE.
    go(HTRANS_NONSEQ, 32'h8800_0000, 1'b1, 32'h0);
    for (int i = 1; i < 4; i++) go(HTRANS_SEQ, 32'h8800_0000 + 32'(i * 4), 1'b1, 32'(100 + i));
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'd104);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

    // Unmapped NONSEQ, mapped NONSEQ during ERR1 ignored, then recovery.
    go(HTRANS_NONSEQ, 32'h9000_0000, 1'b0, 32'h0);
    go(HTRANS_NONSEQ, 32'h8000_0000, 1'b0, 32'h0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

    // Mapped then unmapped back to back.
    go(HTRANS_NONSEQ, 32'h8400_0000, 1'b1, 32'h0);
    go(HTRANS_NONSEQ, 32'h8C00_0000, 1'b1, 32'h55);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h66);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

    // Boundaries and BUSY.
    go(HTRANS_NONSEQ, 32'h8BFF_FFFC, 1'b0, 32'h0);
    go(HTRANS_NONSEQ, 32'h83FF_FFFF, 1'b0, 32'h0);
    go(HTRANS_BUSY, 32'h8000_0000, 1'b0, 32'h0);
    go(HTRANS_NONSEQ, 32'h7FFF_FFFC, 1'b0, 32'h0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    go(HTRANS_NONSEQ, 32'hFFFF_FFFC, 1'b0, 32'h0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

    // Wait states mid-burst hold the pipeline.
    go(HTRANS_NONSEQ, 32'h8000_0100, 1'b1, 32'h0);
    go(HTRANS_SEQ, 32'h8000_0104, 1'b1, 32'h11);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, HTRANS_SEQ, 32'h8000_0108, 1'b1, 32'hAA00 + 32'(i), 1'b0, 32'h0, 1'b0);
    go(HTRANS_SEQ, 32'h8000_0108, 1'b1, 32'h22);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h33);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

    // Reset during ERR1.
    go(HTRANS_NONSEQ, 32'h9000_0000, 1'b1, 32'h0);
    cyc(1'b1, HTRANS_NONSEQ, 32'h8000_0000, 1'b1, 32'h77, 1'b1, 32'h0, 1'b1);
    cyc(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    go(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

    // Random traffic around the window edges.
    addr_pool[0] = BASE - 32'd4;       addr_pool[1] = BASE;
    addr_pool[2] = BASE + SPAN - 32'd4; addr_pool[3] = BASE + SPAN;
    addr_pool[4] = BASE + 2 * SPAN + 32'h40; addr_pool[5] = BASE + 3 * SPAN - 32'd4;
    addr_pool[6] = BASE + 3 * SPAN;    addr_pool[7] = 32'h0;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom() : addr_pool[$urandom_range(0, 7)];
      cyc(1'b0, 2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), $urandom(),
          ($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
